// File: rtl/dmem_pkg.sv
// Shared constants for the data-memory responder: funct3 size/sign fields,
// FSM state encoding and the latency-counter width helper.
package dmem_pkg;

    localparam logic [1:0] SZ_B = 2'b00;
    localparam logic [1:0] SZ_H = 2'b01;
    localparam logic [1:0] SZ_W = 2'b10;
    localparam int         F3_UNSIGNED_BIT = 2;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        WAIT   = 2'd2,
        DONE   = 2'd3
    } state_e;

    // Counter runs 0..LATENCY-1, so it needs clog2(LATENCY) bits (at least one).
    function automatic int lat_cnt_w(input int lat);
        return (lat <= 1) ? 1 : $clog2(lat);
    endfunction

endpackage

// File: rtl/dmem_ctrl_load_align.sv
// Load extraction: picks the byte/half addressed by addr_lo out of the SRAM
// word and sign- or zero-extends it according to funct3.
module load_align
    import dmem_pkg::*;
(
    input  logic [31:0] sram_rdata,
    input  logic [1:0]  addr_lo,
    input  logic [2:0]  funct3,
    output logic [31:0] ext
);

    logic [31:0] shifted;
    logic        uns;

    always_comb begin
        shifted = sram_rdata >> {addr_lo, 3'b000};
        uns     = funct3[F3_UNSIGNED_BIT];
        ext     = sram_rdata;
        case (funct3[1:0])
            SZ_B:    ext = uns ? {24'b0, shifted[7:0]}
                           : {{24{shifted[7]}}, shifted[7:0]};
            SZ_H:    ext = uns ? {16'b0, shifted[15:0]}
                           : {{16{shifted[15]}}, shifted[15:0]};
            default: ext = sram_rdata;
        endcase
    end

endmodule

// File: rtl/dmem_ctrl.sv
// Data-memory responder for the multi-cycle core: one load/store per request,
// lane steering, load extension, misalignment handling (DMEM_MISALIGN_TRAP_EN).
module dmem_ctrl
    import dmem_pkg::*;
#(
    parameter int ADDR_W  = 10,
    parameter int LATENCY = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req,
    input  logic              we,
    input  logic [2:0]        funct3,
    input  logic [31:0]       addr,
    input  logic [31:0]       wdata,
    output logic              mem_busy,
    output logic [31:0]       rdata,
    output logic              misaligned,
    output logic              sram_en,
    output logic [3:0]        sram_we,
    output logic [ADDR_W-1:0] sram_addr,
    output logic [31:0]       sram_wdata,
    input  logic [31:0]       sram_rdata
);

    localparam int             CNT_W    = lat_cnt_w(LATENCY);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(LATENCY - 1);

    state_e              state_q, state_d;
    logic                we_q, we_d;
    logic [2:0]          f3_q, f3_d;
    logic [ADDR_W+1:0]   addr_q, addr_d;
    logic [31:0]         wdata_q, wdata_d;
    logic                busy_q, busy_d;
    logic [31:0]         rdata_q, rdata_d;
    logic                mis_q, mis_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;

    logic                req_mis;
    logic [31:0]         req_addr;
    logic [31:0]         ld_ext;

    // Request-side alignment check; without the trap the low bits are simply
    // forced to natural alignment and the access goes ahead.
    always_comb begin
        req_addr = addr;
`ifdef DMEM_MISALIGN_TRAP_EN
        req_mis = ((funct3[1:0] == SZ_H) && addr[0]) ||
                  (funct3[1] && (addr[1:0] != 2'b00));
`else
        req_mis = 1'b0;
        if (funct3[1])
            req_addr[1:0] = 2'b00;
        else if (funct3[1:0] == SZ_H)
            req_addr[0] = 1'b0;
`endif
    end

    load_align u_load_align (
        .sram_rdata (sram_rdata),
        .addr_lo    (addr_q[1:0]),
        .funct3     (f3_q),
        .ext        (ld_ext)
    );

    always_comb begin
        state_d    = state_q;
        we_d       = we_q;
        f3_d       = f3_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        busy_d     = busy_q;
        rdata_d    = rdata_q;
        mis_d      = mis_q;
        cnt_d      = cnt_q;
        sram_en    = 1'b0;
        sram_we    = 4'b0000;
        sram_addr  = '0;
        sram_wdata = '0;

        case (state_q)
            IDLE: begin
                if (req) begin
                    we_d    = we;
                    f3_d    = funct3;
                    addr_d  = req_addr[ADDR_W+1:0];
                    wdata_d = wdata;
                    mis_d   = req_mis;
                    busy_d  = 1'b1;
                    state_d = ACCESS;
                end
            end
            ACCESS: begin
                sram_addr = addr_q[ADDR_W+1:2];
                case (f3_q[1:0])
                    SZ_B:    sram_wdata = {4{wdata_q[7:0]}};
                    SZ_H:    sram_wdata = {2{wdata_q[15:0]}};
                    default: sram_wdata = wdata_q;
                endcase
                cnt_d = '0;
                if (mis_q) begin
                    busy_d  = 1'b0;
                    state_d = DONE;
                end else if (we_q) begin
                    sram_en = 1'b1;
                    case (f3_q[1:0])
                        SZ_B:    sram_we = 4'b0001 << addr_q[1:0];
                        SZ_H:    sram_we = 4'b0011 << {addr_q[1], 1'b0};
                        default: sram_we = 4'b1111;
                    endcase
                    busy_d  = 1'b0;
                    state_d = DONE;
                end else begin
                    sram_en = 1'b1;
                    state_d = WAIT;
                end
            end
            WAIT: begin
                if (cnt_q == CNT_LAST) begin
                    rdata_d = ld_ext;
                    busy_d  = 1'b0;
                    state_d = DONE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                busy_d  = 1'b0;
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            we_q    <= 1'b0;
            f3_q    <= '0;
            addr_q  <= '0;
            wdata_q <= '0;
            busy_q  <= 1'b0;
            rdata_q <= '0;
            mis_q   <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            we_q    <= we_d;
            f3_q    <= f3_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            busy_q  <= busy_d;
            rdata_q <= rdata_d;
            mis_q   <= mis_d;
            cnt_q   <= cnt_d;
        end
    end

    assign mem_busy   = busy_q;
    assign rdata      = rdata_q;
    assign misaligned = mis_q;

endmodule

// File: tb/tb_dmem_ctrl.sv
// Directed bench for dmem_ctrl: a LATENCY=1 and a LATENCY=3 instance, each
// backed by a small SRAM model; expectations are hand-computed constants.
module tb_dmem_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic        req, sel;
    logic        we_i;
    logic [2:0]  funct3_i;
    logic [31:0] addr_i, wdata_i;

    logic        busy1, mis1, en1, busy3, mis3, en3;
    logic [31:0] rdata1, rdata3, swd1, swd3, srd1, srd3;
    logic [3:0]  swe1, swe3;
    logic [9:0]  sad1, sad3;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    dmem_ctrl #(.ADDR_W(10), .LATENCY(1)) u_dut1 (
        .clk(clk), .reset(reset), .req(req & ~sel), .we(we_i), .funct3(funct3_i),
        .addr(addr_i), .wdata(wdata_i), .mem_busy(busy1), .rdata(rdata1),
        .misaligned(mis1), .sram_en(en1), .sram_we(swe1), .sram_addr(sad1),
        .sram_wdata(swd1), .sram_rdata(srd1)
    );

    dmem_ctrl #(.ADDR_W(10), .LATENCY(3)) u_dut3 (
        .clk(clk), .reset(reset), .req(req & sel), .we(we_i), .funct3(funct3_i),
        .addr(addr_i), .wdata(wdata_i), .mem_busy(busy3), .rdata(rdata3),
        .misaligned(mis3), .sram_en(en3), .sram_we(swe3), .sram_addr(sad3),
        .sram_wdata(swd3), .sram_rdata(srd3)
    );

    // SRAM models: read data appears LATENCY cycles after the enable cycle.
    logic [31:0] mem1 [1024];
    logic [31:0] mem3 [1024];
    logic [31:0] p3 [3];

    always @(posedge clk) begin
        if (en1) begin
            for (int b = 0; b < 4; b++)
                if (swe1[b]) mem1[sad1][b*8 +: 8] <= swd1[b*8 +: 8];
            srd1 <= mem1[sad1];
        end
    end

    always @(posedge clk) begin
        if (en3) begin
            for (int b = 0; b < 4; b++)
                if (swe3[b]) mem3[sad3][b*8 +: 8] <= swd3[b*8 +: 8];
            p3[0] <= mem3[sad3];
        end
        p3[1] <= p3[0];
        p3[2] <= p3[1];
    end
    assign srd3 = p3[2];

    wire        busy_s = sel ? busy3 : busy1;
    wire        en_s   = sel ? en3   : en1;
    wire        mis_s  = sel ? mis3  : mis1;
    wire [31:0] rd_s   = sel ? rdata3 : rdata1;
    wire [3:0]  swe_s  = sel ? swe3  : swe1;
    wire [9:0]  sad_s  = sel ? sad3  : sad1;
    wire [31:0] swd_s  = sel ? swd3  : swd1;

    logic        acc_en, acc_mis;
    logic [3:0]  acc_we;
    logic [9:0]  acc_addr;
    logic [31:0] acc_wd;
    int          nbusy, nen;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // One request from IDLE; records the ACCESS-cycle SRAM signals and the
    // number of busy / enable cycles, and returns with the DUT back in IDLE.
    task automatic xfer(input logic s, input logic w, input logic [2:0] f3,
                        input logic [31:0] a, input logic [31:0] d);
        sel = s; we_i = w; funct3_i = f3; addr_i = a; wdata_i = d; req = 1'b1;
        @(negedge clk);
        req      = 1'b0;
        acc_en   = en_s;
        acc_we   = swe_s;
        acc_addr = sad_s;
        acc_wd   = swd_s;
        acc_mis  = mis_s;
        nbusy = 0;
        nen   = 0;
        while (busy_s && nbusy < 20) begin
            nbusy++;
            if (en_s) nen++;
            @(negedge clk);
        end
        if (nbusy >= 20) chk("busy_timeout", 32'(nbusy), 32'd0);
        @(negedge clk);
    endtask

    initial begin
        reset = 1'b1; req = 1'b0; sel = 1'b0; we_i = 1'b0;
        funct3_i = 3'b0; addr_i = '0; wdata_i = '0;
        @(negedge clk);
        @(negedge clk);
        chk("rst_busy", {31'b0, busy1}, 32'd0);
        chk("rst_rdata", rdata1, 32'd0);
        chk("rst_mis", {31'b0, mis1}, 32'd0);
        chk("rst_sram", {en1, swe1, sad1}, 32'd0);
        chk("rst_wdata", swd1, 32'd0);
        reset = 1'b0;
        @(negedge clk);

        // SW 0x10
        xfer(0, 1, 3'b010, 32'h10, 32'hDEADBEEF);
        chk("sw_en", {31'b0, acc_en}, 32'd1);
        chk("sw_we", {28'b0, acc_we}, 32'hF);
        chk("sw_addr", {22'b0, acc_addr}, 32'd4);
        chk("sw_wdata", acc_wd, 32'hDEADBEEF);
        chk("sw_busy", 32'(nbusy), 32'd1);
        xfer(0, 0, 3'b010, 32'h10, 32'h0);
        chk("lw_back", rdata1, 32'hDEADBEEF);
        chk("lw_busy", 32'(nbusy), 32'd2);

        // word 4 = 0x80123456
        xfer(0, 1, 3'b010, 32'h10, 32'h80123456);
        xfer(0, 0, 3'b000, 32'h13, 32'h0);
        chk("lb", rdata1, 32'hFFFFFF80);
        chk("lb_busy", 32'(nbusy), 32'd2);
        xfer(0, 0, 3'b100, 32'h13, 32'h0);
        chk("lbu", rdata1, 32'h00000080);
        xfer(0, 0, 3'b001, 32'h12, 32'h0);
        chk("lh", rdata1, 32'hFFFF8012);
        xfer(0, 0, 3'b101, 32'h10, 32'h0);
        chk("lhu", rdata1, 32'h00003456);

        // byte and half stores
        xfer(0, 1, 3'b000, 32'h11, 32'h123456A5);
        chk("sb_we", {28'b0, acc_we}, 32'h2);
        chk("sb_wdata", acc_wd, 32'hA5A5A5A5);
        xfer(0, 0, 3'b010, 32'h10, 32'h0);
        chk("sb_merge", rdata1, 32'h8012A556);
        xfer(0, 1, 3'b001, 32'h12, 32'h0000BEEF);
        chk("sh_we", {28'b0, acc_we}, 32'hC);
        chk("sh_wdata", acc_wd, 32'hBEEFBEEF);
        xfer(0, 0, 3'b010, 32'h10, 32'h0);
        chk("sh_merge", rdata1, 32'hBEEFA556);
        chk("st_no_rdata", rdata1, 32'hBEEFA556);
        xfer(0, 1, 3'b010, 32'h4, 32'h0BADF00D);
        chk("st_keeps_rdata", rdata1, 32'hBEEFA556);

        // misaligned LW 0x6
        xfer(0, 0, 3'b010, 32'h6, 32'h0);
`ifdef DMEM_MISALIGN_TRAP_EN
        chk("mis_flag", {31'b0, acc_mis}, 32'd1);
        chk("mis_no_en", 32'(nen), 32'd0);
        chk("mis_busy", 32'(nbusy), 32'd1);
        chk("mis_rdata", rdata1, 32'hBEEFA556);
        chk("mis_hold", {31'b0, mis1}, 32'd1);
`else
        chk("mis_flag", {31'b0, acc_mis}, 32'd0);
        chk("mis_addr", {22'b0, acc_addr}, 32'd1);
        chk("mis_busy", 32'(nbusy), 32'd2);
        chk("mis_rdata", rdata1, 32'h0BADF00D);
`endif

        // req while busy is ignored: LB 0x13, then LBU 0x10 pulsed mid-access
        sel = 0; we_i = 0; funct3_i = 3'b000; addr_i = 32'h13; req = 1'b1;
        @(negedge clk);
        funct3_i = 3'b100; addr_i = 32'h10;
        nbusy = 0;
        for (int i = 0; i < 3; i++) begin
            if (busy1) nbusy++;
            @(negedge clk);
        end
        req = 1'b0;
        chk("ign_busy", 32'(nbusy), 32'd2);
        chk("ign_rdata", rdata1, 32'hFFFFFFBE);
        @(negedge clk);
        @(negedge clk);
        chk("ign_idle", {30'b0, busy1, en1}, 32'd0);
        chk("ign_mis_clr", {31'b0, mis1}, 32'd0);

        // LATENCY=3 instance
        xfer(1, 1, 3'b010, 32'h10, 32'h80123456);
        xfer(1, 0, 3'b001, 32'h12, 32'h0);
        chk("l3_lh", rdata3, 32'hFFFF8012);
        chk("l3_busy", 32'(nbusy), 32'd4);
        chk("l3_en", 32'(nen), 32'd1);

        // reset asserted during WAIT
        sel = 1; we_i = 0; funct3_i = 3'b010; addr_i = 32'h10; req = 1'b1;
        @(negedge clk);
        req = 1'b0;
        @(negedge clk);
        chk("l3_wait_busy", {31'b0, busy3}, 32'd1);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        chk("rstw_busy", {31'b0, busy3}, 32'd0);
        chk("rstw_rdata", rdata3, 32'd0);
        chk("rstw_en", {31'b0, en3}, 32'd0);
        @(negedge clk);
        chk("rstw_quiet", {30'b0, busy3, en3}, 32'd0);
        xfer(1, 0, 3'b100, 32'h13, 32'h0);
        chk("l3_lbu", rdata3, 32'h00000080);
        chk("l3_lbu_busy", 32'(nbusy), 32'd4);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
